cpu_control_sequencer: RTL and testbench
========================================

Name: cpu_control_sequencer

Overview:
- Hardwired control unit for the 4-bit accumulator microprocessor.
- Runs a fetch/decode/execute T-state sequence and drives every bus-enable and latch strobe for PC, MAR, RAM, IR, accumulator A, register B, ALU and output register.
- Guarantees at most one bus driver per cycle.
- Sits beside the datapath; all strobes are consumed on the next MainClock rising edge.

Parameters:
- OPCODE_WIDTH, 4, width of opcode field from IR.
- AUTO_RUN, 0, 1 = leave IDLE on first cycle after Clear without waiting for Start.

Ports:
- MainClock  input  1  system clock, rising edge.
- Clear  input  1  synchronous active-high reset.
- Start  input  1  level; leaves IDLE when high.
- Opcode  input  OPCODE_WIDTH  IR upper nibble, valid from T4.
- ZeroFlag  input  1  ALU zero flag (A == 0).
- CarryFlag  input  1  ALU carry-out flag.
- EnablePC  output  1  PC drives bus.
- IncPC  output  1  PC increment.
- LatchPC  output  1  PC loads bus.
- LatchMAR  output  1  MAR loads bus.
- EnableRAM  output  1  RAM[MAR] drives bus.
- LatchIR  output  1  IR loads bus.
- EnableIR  output  1  IR operand nibble drives bus.
- LatchA  output  1  accumulator loads bus.
- EnableA  output  1  accumulator drives bus.
- ClearA  output  1  accumulator clear.
- LatchB  output  1  B loads bus.
- EnableALU  output  1  ALU result drives bus.
- SubALU  output  1  ALU subtract select.
- LatchOut  output  1  output register loads bus.
- Halted  output  1  HALT state indicator.
- TState  output  3  current T-state (0 = IDLE/HALT, 1..6).

Behaviour:
- States: IDLE, T1..T6, HALT. Clear from any state, including mid-instruction: next state IDLE, all strobes 0, Halted=0, TState=0.
- IDLE -> T1 when Start=1, or unconditionally if AUTO_RUN=1. IDLE outputs all 0.
- Moore outputs: strobes are combinational from the state register plus Opcode/flags only. No strobe is asserted in IDLE or HALT.
- Fetch, identical for all opcodes:
  - T1: EnablePC, LatchMAR.
  - T2: IncPC.
  - T3: EnableRAM, LatchIR.
- Execute, with "done" meaning next state is T1:
  - 0 NOP: T4 none; done.
  - 1 LDA: T4 EnableIR+LatchMAR; T5 EnableRAM+LatchA; done.
  - 2 ADD: T4 EnableIR+LatchMAR; T5 EnableRAM+LatchB; T6 EnableALU+LatchA; done.
  - 3 SUB: as ADD, with SubALU=1 in T6 only.
  - 4 OUT: T4 EnableA+LatchOut; done.
  - 5 JMP: T4 EnableIR+LatchPC; done.
  - 6 JZ: T4 EnableIR+LatchPC only if ZeroFlag=1, else none; done.
  - 7 JC: as JZ using CarryFlag.
  - 8 CLA: T4 ClearA; done.
  - F HLT: T4 -> HALT; Halted=1 until Clear.
  - 9..E: treated as NOP.
- Flags are sampled combinationally in T4.
- Start is ignored outside IDLE.
- Invariant: at most one of EnablePC, EnableRAM, EnableIR, EnableA, EnableALU is high in any cycle. Violation is a design error.
- Instruction length: NOP/OUT/JMP/JZ/JC/CLA take 4 cycles, LDA 5, ADD/SUB 6.

Optional Feature:
- Macro SINGLE_STEP_EN.
- Defined:
  - Adds inputs StepMode and Step (1 bit each).
  - Step is registered; its rising edge is detected internally.
  - With StepMode=1, T-state advances only in cycles where a Step rising edge is detected. Strobes are asserted only in that advance cycle, and are 0 while waiting.
  - With StepMode=0, behaviour is normal.
  - Clear also resets the Step history register.
- Undefined: ports absent; advances every cycle.

Decomposition:
- Shared package cpu_pkg:
  - opcode constants OP_NOP..OP_HLT;
  - state enum (IDLE, T1..T6, HALT) with 3-bit encoding matching TState;
  - control-word struct/bit indices shared with the datapath top.
- One sub-module: cpu_control_decode, purely combinational (state, Opcode, flags -> control word, next-state "done/halt" hints). The sequencer keeps the state register and step logic.

Test Plan:
- Clear held 2 cycles mid-ADD at T5 -> next cycle TState=0, all strobes 0; with Start=1, T1 follows with EnablePC+LatchMAR.
- Opcode=1 (LDA) -> T1..T5 strobes exactly as listed; back to T1 in the cycle after T5; 5-cycle period.
- Opcode=3 (SUB) -> SubALU=1 only in T6 together with EnableALU+LatchA; 6-cycle period.
- Opcode=6 (JZ): ZeroFlag=0 -> no LatchPC in T4; ZeroFlag=1 -> EnableIR+LatchPC in T4.
- Opcode=F -> HALT after T4; Halted=1 for 20+ cycles regardless of Start; Clear returns to IDLE.
- Every cycle over a random opcode stream of 200 instructions: assert one-hot-or-zero bus enables. With SINGLE_STEP_EN, StepMode=1 and 3 Step pulses -> exactly T1, T2, T3 visited.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared definitions for the 4-bit accumulator CPU control path.
// Opcodes, T-state encoding and the control-word layout used by the datapath.
package cpu_pkg;

   localparam logic [3:0] OP_NOP = 4'h0;
   localparam logic [3:0] OP_LDA = 4'h1;
   localparam logic [3:0] OP_ADD = 4'h2;
   localparam logic [3:0] OP_SUB = 4'h3;
   localparam logic [3:0] OP_OUT = 4'h4;
   localparam logic [3:0] OP_JMP = 4'h5;
   localparam logic [3:0] OP_JZ  = 4'h6;
   localparam logic [3:0] OP_JC  = 4'h7;
   localparam logic [3:0] OP_CLA = 4'h8;
   localparam logic [3:0] OP_HLT = 4'hF;

   // Encodings of IDLE and T1..T6 equal the TState value they report.
   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_T1   = 3'd1,
      S_T2   = 3'd2,
      S_T3   = 3'd3,
      S_T4   = 3'd4,
      S_T5   = 3'd5,
      S_T6   = 3'd6,
      S_HALT = 3'd7
   } state_t;

   typedef struct packed {
      logic en_pc;
      logic inc_pc;
      logic latch_pc;
      logic latch_mar;
      logic en_ram;
      logic latch_ir;
      logic en_ir;
      logic latch_a;
      logic en_a;
      logic clear_a;
      logic latch_b;
      logic en_alu;
      logic sub_alu;
      logic latch_out;
   } ctrl_t;

   localparam int CTRL_W = 14;

endpackage

// File: rtl/cpu_control_decode.sv
// Combinational decode: T-state, opcode and flags to control word.
// Also reports whether the instruction ends (done) or halts this cycle.
module cpu_control_decode
   import cpu_pkg::*;
#(
   parameter int OPCODE_WIDTH = 4
) (
   input  state_t                  state,
   input  logic [OPCODE_WIDTH-1:0] opcode,
   input  logic                    zero_flag,
   input  logic                    carry_flag,
   output ctrl_t                   ctrl,
   output logic                    done,
   output logic                    halt
);

   logic [3:0] op;

   assign op = 4'(opcode);

   // Per-state strobe generation; execute steps depend on the opcode.
   always_comb begin
      ctrl = '0;
      done = 1'b0;
      halt = 1'b0;
      case (state)
         S_T1: begin
            ctrl.en_pc     = 1'b1;
            ctrl.latch_mar = 1'b1;
         end
         S_T2: ctrl.inc_pc = 1'b1;
         S_T3: begin
            ctrl.en_ram   = 1'b1;
            ctrl.latch_ir = 1'b1;
         end
         S_T4: begin
            done = 1'b1;
            case (op)
               OP_LDA, OP_ADD, OP_SUB: begin
                  ctrl.en_ir     = 1'b1;
                  ctrl.latch_mar = 1'b1;
                  done           = 1'b0;
               end
               OP_OUT: begin
                  ctrl.en_a      = 1'b1;
                  ctrl.latch_out = 1'b1;
               end
               OP_JMP: begin
                  ctrl.en_ir    = 1'b1;
                  ctrl.latch_pc = 1'b1;
               end
               OP_JZ: begin
                  ctrl.en_ir    = zero_flag;
                  ctrl.latch_pc = zero_flag;
               end
               OP_JC: begin
                  ctrl.en_ir    = carry_flag;
                  ctrl.latch_pc = carry_flag;
               end
               OP_CLA: ctrl.clear_a = 1'b1;
               OP_HLT: begin
                  done = 1'b0;
                  halt = 1'b1;
               end
               default: ;
            endcase
         end
         S_T5: begin
            ctrl.en_ram = 1'b1;
            if (op == OP_LDA) begin
               ctrl.latch_a = 1'b1;
               done         = 1'b1;
            end else if (op == OP_ADD || op == OP_SUB) begin
               ctrl.latch_b = 1'b1;
            end else begin
               // Opcode changed under us: drop out safely.
               ctrl.en_ram = 1'b0;
               done        = 1'b1;
            end
         end
         S_T6: begin
            ctrl.en_alu  = 1'b1;
            ctrl.latch_a = 1'b1;
            ctrl.sub_alu = (op == OP_SUB);
            done         = 1'b1;
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/cpu_control_sequencer.sv
// T-state sequencer for the accumulator CPU; owns the state register.
// Optional macro SINGLE_STEP_EN adds StepMode/Step manual stepping.
module cpu_control_sequencer
   import cpu_pkg::*;
#(
   parameter int OPCODE_WIDTH = 4,
   parameter int AUTO_RUN     = 0
) (
   input  logic                    MainClock,
   input  logic                    Clear,
   input  logic                    Start,
   input  logic [OPCODE_WIDTH-1:0] Opcode,
   input  logic                    ZeroFlag,
   input  logic                    CarryFlag,
`ifdef SINGLE_STEP_EN
   input  logic                    StepMode,
   input  logic                    Step,
`endif
   output logic                    EnablePC,
   output logic                    IncPC,
   output logic                    LatchPC,
   output logic                    LatchMAR,
   output logic                    EnableRAM,
   output logic                    LatchIR,
   output logic                    EnableIR,
   output logic                    LatchA,
   output logic                    EnableA,
   output logic                    ClearA,
   output logic                    LatchB,
   output logic                    EnableALU,
   output logic                    SubALU,
   output logic                    LatchOut,
   output logic                    Halted,
   output logic [2:0]              TState
);

   state_t state;
   state_t state_nxt;
   ctrl_t  dec_ctrl;
   ctrl_t  ctrl;
   logic   dec_done;
   logic   dec_halt;
   logic   advance;

   cpu_control_decode #(
      .OPCODE_WIDTH(OPCODE_WIDTH)
   ) u_decode (
      .state      (state),
      .opcode     (Opcode),
      .zero_flag  (ZeroFlag),
      .carry_flag (CarryFlag),
      .ctrl       (dec_ctrl),
      .done       (dec_done),
      .halt       (dec_halt)
   );

`ifdef SINGLE_STEP_EN
   logic step_q;

   // Step history for rising-edge detection.
   always_ff @(posedge MainClock) begin
      if (Clear) step_q <= 1'b0;
      else       step_q <= Step;
   end

   assign advance = !StepMode || (Step && !step_q);
`else
   assign advance = 1'b1;
`endif

   // State register with synchronous clear.
   always_ff @(posedge MainClock) begin
      if (Clear) state <= S_IDLE;
      else       state <= state_nxt;
   end

   // Next-state sequencing; decode hints end or halt the instruction.
   always_comb begin
      state_nxt = state;
      if (advance) begin
         case (state)
            S_IDLE: if (Start || AUTO_RUN != 0) state_nxt = S_T1;
            S_T1:   state_nxt = S_T2;
            S_T2:   state_nxt = S_T3;
            S_T3:   state_nxt = S_T4;
            S_T4: begin
               if (dec_halt)      state_nxt = S_HALT;
               else if (dec_done) state_nxt = S_T1;
               else               state_nxt = S_T5;
            end
            S_T5:   state_nxt = dec_done ? S_T1 : S_T6;
            S_T6:   state_nxt = S_T1;
            S_HALT: state_nxt = S_HALT;
            default: state_nxt = S_IDLE;
         endcase
      end
   end

   // Moore outputs; strobes held low while waiting for a step.
   always_comb begin
      ctrl      = advance ? dec_ctrl : '0;
      EnablePC  = ctrl.en_pc;
      IncPC     = ctrl.inc_pc;
      LatchPC   = ctrl.latch_pc;
      LatchMAR  = ctrl.latch_mar;
      EnableRAM = ctrl.en_ram;
      LatchIR   = ctrl.latch_ir;
      EnableIR  = ctrl.en_ir;
      LatchA    = ctrl.latch_a;
      EnableA   = ctrl.en_a;
      ClearA    = ctrl.clear_a;
      LatchB    = ctrl.latch_b;
      EnableALU = ctrl.en_alu;
      SubALU    = ctrl.sub_alu;
      LatchOut  = ctrl.latch_out;
      Halted    = (state == S_HALT);
      TState    = (state == S_HALT) ? 3'd0 : 3'(state);
   end

endmodule

// File: tb/tb_cpu_control_sequencer.sv
// Directed self-checking bench for cpu_control_sequencer.
// Covers fetch/execute strobes, clear, halt, jumps and bus exclusivity.
module tb_cpu_control_sequencer;

   localparam logic [13:0] EPC  = 14'd1 << 13;
   localparam logic [13:0] INC  = 14'd1 << 12;
   localparam logic [13:0] LPC  = 14'd1 << 11;
   localparam logic [13:0] LMAR = 14'd1 << 10;
   localparam logic [13:0] ERAM = 14'd1 << 9;
   localparam logic [13:0] LIR  = 14'd1 << 8;
   localparam logic [13:0] EIR  = 14'd1 << 7;
   localparam logic [13:0] LA   = 14'd1 << 6;
   localparam logic [13:0] EA   = 14'd1 << 5;
   localparam logic [13:0] CLRA = 14'd1 << 4;
   localparam logic [13:0] LB   = 14'd1 << 3;
   localparam logic [13:0] EALU = 14'd1 << 2;
   localparam logic [13:0] SUBA = 14'd1 << 1;
   localparam logic [13:0] LOUT = 14'd1;

   logic       MainClock = 1'b0;
   logic       Clear = 1'b1;
   logic       Start = 1'b0;
   logic [3:0] Opcode = 4'h0;
   logic       ZeroFlag = 1'b0;
   logic       CarryFlag = 1'b0;
`ifdef SINGLE_STEP_EN
   logic       StepMode = 1'b0;
   logic       Step = 1'b0;
`endif
   logic EnablePC, IncPC, LatchPC, LatchMAR, EnableRAM, LatchIR;
   logic EnableIR, LatchA, EnableA, ClearA, LatchB, EnableALU;
   logic SubALU, LatchOut, Halted;
   logic [2:0] TState;
   logic [13:0] obs;

   int checks = 0;
   int errors = 0;

   cpu_control_sequencer #(
      .OPCODE_WIDTH(4),
      .AUTO_RUN(0)
   ) dut (
      .MainClock(MainClock),
      .Clear(Clear),
      .Start(Start),
      .Opcode(Opcode),
      .ZeroFlag(ZeroFlag),
      .CarryFlag(CarryFlag),
`ifdef SINGLE_STEP_EN
      .StepMode(StepMode),
      .Step(Step),
`endif
      .EnablePC(EnablePC),
      .IncPC(IncPC),
      .LatchPC(LatchPC),
      .LatchMAR(LatchMAR),
      .EnableRAM(EnableRAM),
      .LatchIR(LatchIR),
      .EnableIR(EnableIR),
      .LatchA(LatchA),
      .EnableA(EnableA),
      .ClearA(ClearA),
      .LatchB(LatchB),
      .EnableALU(EnableALU),
      .SubALU(SubALU),
      .LatchOut(LatchOut),
      .Halted(Halted),
      .TState(TState)
   );

   always #5 MainClock = ~MainClock;

   assign obs = {EnablePC, IncPC, LatchPC, LatchMAR, EnableRAM, LatchIR,
                 EnableIR, LatchA, EnableA, ClearA, LatchB, EnableALU,
                 SubALU, LatchOut};

   task automatic tick();
      @(posedge MainClock);
      #1;
   endtask

   // Clear for a cycle, then arm Start; the next tick lands in T1.
   task automatic begin_instr(input logic [3:0] op,
                              input logic zf, input logic cf);
      Clear = 1'b1;
      tick();
      Clear = 1'b0;
      Start = 1'b1;
      Opcode = op;
      ZeroFlag = zf;
      CarryFlag = cf;
   endtask

   task automatic test_reset();
      Clear = 1'b1;
      Start = 1'b1;
      tick();
      tick();
      checks++;
      if (TState !== 3'd0 || obs !== 14'd0 || Halted !== 1'b0) begin
         errors++;
         $display("FAIL reset: tstate=%0d strobes=%h halted=%b want 0/0/0",
                  TState, obs, Halted);
      end
      Clear = 1'b0;
      Start = 1'b0;
      tick();
      checks++;
      if (TState !== 3'd0) begin
         errors++;
         $display("FAIL idle_hold: tstate=%0d want 0", TState);
      end
   endtask

   task automatic test_lda();
      logic [13:0] exp [5];
      exp = '{EPC|LMAR, INC, ERAM|LIR, EIR|LMAR, ERAM|LA};
      begin_instr(4'h1, 1'b0, 1'b0);
      for (int i = 0; i < 5; i++) begin
         tick();
         checks++;
         if (TState !== 3'(i + 1) || obs !== exp[i]) begin
            errors++;
            $display("FAIL lda_t%0d: tstate=%0d strobes=%h want %0d/%h",
                     i + 1, TState, obs, i + 1, exp[i]);
         end
      end
      tick();
      checks++;
      if (TState !== 3'd1) begin
         errors++;
         $display("FAIL lda_period: tstate=%0d want 1", TState);
      end
   endtask

   task automatic test_add_sub();
      logic [13:0] exp [6];
      for (int k = 0; k < 2; k++) begin
         exp = '{EPC|LMAR, INC, ERAM|LIR, EIR|LMAR, ERAM|LB,
                 (k == 1) ? (EALU|LA|SUBA) : (EALU|LA)};
         begin_instr((k == 1) ? 4'h3 : 4'h2, 1'b0, 1'b0);
         for (int i = 0; i < 6; i++) begin
            tick();
            checks++;
            if (TState !== 3'(i + 1) || obs !== exp[i]) begin
               errors++;
               $display("FAIL addsub%0d_t%0d: tstate=%0d strobes=%h want %0d/%h",
                        k, i + 1, TState, obs, i + 1, exp[i]);
            end
         end
         tick();
         checks++;
         if (TState !== 3'd1) begin
            errors++;
            $display("FAIL addsub%0d_period: tstate=%0d want 1", k, TState);
         end
      end
   endtask

   task automatic test_short_ops();
      logic [3:0]  ops [10];
      logic [1:0]  flg [10];
      logic [13:0] exp [10];
      ops = '{4'h0, 4'h4, 4'h5, 4'h6, 4'h6, 4'h7, 4'h7, 4'h8, 4'h9, 4'hE};
      flg = '{2'b11, 2'b00, 2'b00, 2'b00, 2'b10, 2'b10, 2'b01,
              2'b00, 2'b11, 2'b11};
      exp = '{14'd0, EA|LOUT, EIR|LPC, 14'd0, EIR|LPC, 14'd0, EIR|LPC,
              CLRA, 14'd0, 14'd0};
      for (int k = 0; k < 10; k++) begin
         begin_instr(ops[k], flg[k][1], flg[k][0]);
         repeat (4) tick();
         checks++;
         if (TState !== 3'd4 || obs !== exp[k]) begin
            errors++;
            $display("FAIL op%h_zc%b_t4: tstate=%0d strobes=%h want 4/%h",
                     ops[k], flg[k], TState, obs, exp[k]);
         end
         tick();
         checks++;
         if (TState !== 3'd1) begin
            errors++;
            $display("FAIL op%h_period: tstate=%0d want 1", ops[k], TState);
         end
      end
   endtask

   task automatic test_clear_mid_add();
      begin_instr(4'h2, 1'b0, 1'b0);
      repeat (5) tick();
      checks++;
      if (TState !== 3'd5) begin
         errors++;
         $display("FAIL clr_setup: tstate=%0d want 5", TState);
      end
      Clear = 1'b1;
      for (int i = 0; i < 2; i++) begin
         tick();
         checks++;
         if (TState !== 3'd0 || obs !== 14'd0 || Halted !== 1'b0) begin
            errors++;
            $display("FAIL clr_hold%0d: tstate=%0d strobes=%h halted=%b want 0/0/0",
                     i, TState, obs, Halted);
         end
      end
      Clear = 1'b0;
      tick();
      checks++;
      if (TState !== 3'd1 || obs !== (EPC|LMAR)) begin
         errors++;
         $display("FAIL clr_restart: tstate=%0d strobes=%h want 1/%h",
                  TState, obs, EPC|LMAR);
      end
   endtask

   task automatic test_halt();
      begin_instr(4'hF, 1'b0, 1'b0);
      repeat (4) tick();
      checks++;
      if (TState !== 3'd4 || obs !== 14'd0 || Halted !== 1'b0) begin
         errors++;
         $display("FAIL hlt_t4: tstate=%0d strobes=%h halted=%b want 4/0/0",
                  TState, obs, Halted);
      end
      for (int i = 0; i < 22; i++) begin
         tick();
         Start = i[0];
         checks++;
         if (Halted !== 1'b1 || TState !== 3'd0 || obs !== 14'd0) begin
            errors++;
            $display("FAIL halt_hold%0d: halted=%b tstate=%0d strobes=%h want 1/0/0",
                     i, Halted, TState, obs);
         end
      end
      Clear = 1'b1;
      tick();
      Clear = 1'b0;
      Start = 1'b0;
      checks++;
      if (Halted !== 1'b0 || TState !== 3'd0) begin
         errors++;
         $display("FAIL halt_clear: halted=%b tstate=%0d want 0/0",
                  Halted, TState);
      end
      tick();
      checks++;
      if (TState !== 3'd0) begin
         errors++;
         $display("FAIL halt_idle: tstate=%0d want 0", TState);
      end
   endtask

   task automatic test_random_stream();
      logic [3:0] op;
      int len;
      begin_instr(4'h0, 1'b0, 1'b0);
      tick();
      for (int n = 0; n < 200; n++) begin
         op = 4'($urandom_range(0, 14));
         Opcode = op;
         ZeroFlag = 1'($urandom_range(0, 1));
         CarryFlag = 1'($urandom_range(0, 1));
         #1;
         case (op)
            4'h1:       len = 5;
            4'h2, 4'h3: len = 6;
            default:    len = 4;
         endcase
         for (int c = 1; c <= len; c++) begin
            checks++;
            if (TState !== 3'(c)) begin
               errors++;
               $display("FAIL stream%0d_op%h_t: tstate=%0d want %0d",
                        n, op, TState, c);
            end
            checks++;
            if ($countones({EnablePC, EnableRAM, EnableIR, EnableA,
                            EnableALU}) > 1) begin
               errors++;
               $display("FAIL stream%0d_bus: strobes=%h want <=1 driver",
                        n, obs);
            end
            tick();
         end
      end
   endtask

`ifdef SINGLE_STEP_EN
   task automatic test_single_step();
      logic [13:0] exp [3];
      exp = '{14'd0, EPC|LMAR, INC};
      StepMode = 1'b1;
      Step = 1'b0;
      begin_instr(4'h2, 1'b0, 1'b0);
      for (int p = 0; p < 3; p++) begin
         repeat (2) tick();
         checks++;
         if (TState !== 3'(p) || obs !== 14'd0) begin
            errors++;
            $display("FAIL step_wait%0d: tstate=%0d strobes=%h want %0d/0",
                     p, TState, obs, p);
         end
         Step = 1'b1;
         #1;
         checks++;
         if (obs !== exp[p]) begin
            errors++;
            $display("FAIL step_strobe%0d: strobes=%h want %h",
                     p, obs, exp[p]);
         end
         tick();
         Step = 1'b0;
         checks++;
         if (TState !== 3'(p + 1)) begin
            errors++;
            $display("FAIL step_adv%0d: tstate=%0d want %0d",
                     p, TState, p + 1);
         end
      end
      repeat (4) tick();
      checks++;
      if (TState !== 3'd3) begin
         errors++;
         $display("FAIL step_stop: tstate=%0d want 3", TState);
      end
      StepMode = 1'b0;
   endtask
`endif

   initial begin
      #1_000_000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      test_reset();
      test_lda();
      test_add_sub();
      test_short_ops();
      test_clear_mid_add();
      test_halt();
      test_random_stream();
`ifdef SINGLE_STEP_EN
      test_single_step();
`endif
      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end

endmodule
